sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-requester arbiter and sequencer for the single-port coefficient/sample SRAM (`SpSram`) in the FIR datapath. It shares the one SRAM port between the host requester A (coefficient load and readback) and the FIR engine requester B (tap/sample fetch). It issues at most one registered SRAM command per cycle and routes the 1-cycle-latency read data back to the issuing requester with a valid pulse.

## Interface
Parameters:
- SRAM_DEPTH, 10, number of SRAM words; must match the attached `SpSram`.
- DATA_WIDTH, 16, data word width.
- ADDR_WIDTH, 4, address width; must equal the SRAM address width (4 for depth 10).

Ports:
- iClk  in  1  clock; rising edge.
- iRsn  in  1  reset; asynchronous, active-low.
- iReqA / iReqB  in  1  request, held until granted.
- iWrnA / iWrnB  in  1  0 = write, 1 = read.
- iAddrA / iAddrB  in  ADDR_WIDTH  access address.
- iWrDtA / iWrDtB  in  DATA_WIDTH  write data.
- oGntA / oGntB  out  1  grant; request accepted this cycle.
- oRdVldA / oRdVldB  out  1  read data valid pulse.
- oRdDtA / oRdDtB  out  DATA_WIDTH  read data; direct copy of iRdDt.
- oCsn  out  1  SRAM chip select, active-low, registered.
- oWrn  out  1  SRAM write/read select, registered.
- oAddr  out  ADDR_WIDTH  SRAM address, registered.
- oWrDt  out  DATA_WIDTH  SRAM write data, registered.
- iRdDt  in  DATA_WIDTH  SRAM read data (`oRdDt` of SpSram).

## Operation
- Handshake: requester asserts iReqX with iWrnX/iAddrX/iWrDtX stable. The transfer completes in the cycle where iReqX && oGntX. The requester may change or drop the command in the next cycle.
- oGntX is combinational from the iReq inputs and the priority state. At most one grant is high per cycle. The grant is forced to 0 while iRsn = 0.
- Only one requester active: it is granted in the same cycle.
- Both requesters active, default behaviour: fixed priority, A wins and B waits.
- Command register: on a grant, the next edge loads oCsn = 0, oWrn = iWrnX, oAddr = iAddrX, oWrDt = iWrDtX. With no grant, the next edge loads oCsn = 1, oWrn = 1, and leaves oAddr/oWrDt unchanged.
- Return tag: a 2-stage pipeline of {valid, requester-id} tracks reads. Stage 1 aligns with the registered command; stage 2 aligns with SpSram's registered output.
  - oRdVldX = stage2.valid && stage2.id == X.
  - Writes do not enter the tag pipeline.
- Out-of-range address (≥ SRAM_DEPTH): the command is passed through unchanged. Data is undefined; the requester is responsible for address range.
- Reset, asynchronous, at any time:
  - oCsn = 1, oWrn = 1, oAddr = 0, oWrDt = 0.
  - Tag pipeline cleared, so oRdVldA = oRdVldB = 0 and in-flight reads are dropped (no valid pulse).
  - Priority pointer set to "last granted = B".
  - oRdDtA/B follow iRdDt, which is 0 after SpSram reset.

## Timing
- Cycle T: iReqX = 1 and oGntX = 1.
- T+1: SRAM command visible on oCsn/oWrn/oAddr/oWrDt; the SRAM samples it at the end of T+1.
- Write: memory is updated at the end of T+1.
- Read: oRdVldX = 1 and oRdDtX valid in T+2. Read latency from grant is 2 cycles.
- Throughput: one grant per cycle, back-to-back, with any mix of requesters and read/write.
- Read-after-write to the same address in consecutive grants returns the new data: the write lands at the end of T+1, the read samples at the end of T+2.
- A request stalled by the other requester keeps iReqX high. There is no timeout; under fixed priority B can starve.

## Configuration
- SP_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit "last granted" register is updated on every grant.
  - On conflict, the requester not granted last wins.
  - A single active requester is always granted immediately.
  - Reset value "last = B", so A wins the first conflict.
- SP_ARB_RR_EN undefined: fixed priority with A over B. The pointer register is not implemented.

## Test plan
- Reset: hold iRsn = 0 mid-stream with a read in flight. Expect oCsn = 1, oWrn = 1, oAddr = 0, oWrDt = 0, oGnt* = 0, oRdVld* = 0 immediately (asynchronous). Expect no valid pulse after release.
- Single requester: A writes 16'h1234 to addr 3, then reads addr 3 in the next cycle. Expect grants in T and T+1, and oRdVldA = 1 with oRdDtA = 16'h1234 at T+3.
- Conflict: iReqA = iReqB = 1 (both reads, addr 1 / addr 2) for 4 cycles.
  - Fixed priority: A granted in all 4 cycles, B never granted.
  - SP_ARB_RR_EN: grants alternate A, B, A, B, and the returns arrive at oRdVldA/oRdVldB with matching data 2 cycles after each grant.
- Return routing: B reads addr 5 (preloaded with 16'hBEEF) at T and A reads addr 6 (16'h0F0F) at T+1. Expect oRdVldB only at T+2 with 16'hBEEF, and oRdVldA only at T+3 with 16'h0F0F.
- Back-to-back fill: B writes addr 0..9 with data 100+addr on consecutive cycles, then reads them back. Expect 10 consecutive oRdVldB pulses with data 100..109 and oCsn low continuously during both bursts.
- Idle: no requests. Expect oCsn = 1, oWrn = 1, oAddr/oWrDt holding their last values, and no valid pulses.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Shares the single SpSram port between the host (A) and the FIR engine (B): one registered command per cycle, tagged read return.
// Build option: define SP_ARB_RR_EN for round-robin arbitration; otherwise A has fixed priority over B.
module sram_port_arbiter #(
  parameter int SRAM_DEPTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  iClk,
  input  logic                  iRsn,
  input  logic                  iReqA,
  input  logic                  iWrnA,
  input  logic [ADDR_WIDTH-1:0] iAddrA,
  input  logic [DATA_WIDTH-1:0] iWrDtA,
  input  logic                  iReqB,
  input  logic                  iWrnB,
  input  logic [ADDR_WIDTH-1:0] iAddrB,
  input  logic [DATA_WIDTH-1:0] iWrDtB,
  output logic                  oGntA,
  output logic                  oGntB,
  output logic                  oRdVldA,
  output logic                  oRdVldB,
  output logic [DATA_WIDTH-1:0] oRdDtA,
  output logic [DATA_WIDTH-1:0] oRdDtB,
  output logic                  oCsn,
  output logic                  oWrn,
  output logic [ADDR_WIDTH-1:0] oAddr,
  output logic [DATA_WIDTH-1:0] oWrDt,
  input  logic [DATA_WIDTH-1:0] iRdDt
);

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  if (SRAM_DEPTH > (1 << ADDR_WIDTH)) begin : gCfgCheck
    $error("sram_port_arbiter: ADDR_WIDTH too small for SRAM_DEPTH");
  end

  logic gntA;
  logic gntB;

`ifdef SP_ARB_RR_EN
  // lastB = 1 means B was granted most recently, so A wins the next conflict
  logic lastB;

  always_comb begin
    gntA = iRsn && iReqA && (!iReqB || lastB);
    gntB = iRsn && iReqB && (!iReqA || !lastB);
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      lastB <= 1'b1;
    end else if (gntA || gntB) begin
      lastB <= gntB;
    end
  end
`else
  always_comb begin
    gntA = iRsn && iReqA;
    gntB = iRsn && iReqB && !iReqA;
  end
`endif

  assign oGntA = gntA;
  assign oGntB = gntB;

  // Address and write data hold their last values while idle
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      oCsn  <= 1'b1;
      oWrn  <= 1'b1;
      oAddr <= '0;
      oWrDt <= '0;
    end else if (gntA) begin
      oCsn  <= 1'b0;
      oWrn  <= iWrnA;
      oAddr <= iAddrA;
      oWrDt <= iWrDtA;
    end else if (gntB) begin
      oCsn  <= 1'b0;
      oWrn  <= iWrnB;
      oAddr <= iAddrB;
      oWrDt <= iWrDtB;
    end else begin
      oCsn  <= 1'b1;
      oWrn  <= 1'b1;
    end
  end

  // Stage 1 lines up with the registered command, stage 2 with the SRAM output register
  logic tag1Vld;
  logic tag1Id;
  logic tag2Vld;
  logic tag2Id;

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      tag1Vld <= 1'b0;
      tag1Id  <= ID_A;
      tag2Vld <= 1'b0;
      tag2Id  <= ID_A;
    end else begin
      tag1Vld <= (gntA && iWrnA) || (gntB && iWrnB);
      tag1Id  <= gntB ? ID_B : ID_A;
      tag2Vld <= tag1Vld;
      tag2Id  <= tag1Id;
    end
  end

  assign oRdVldA = tag2Vld && (tag2Id == ID_A);
  assign oRdVldB = tag2Vld && (tag2Id == ID_B);
  assign oRdDtA  = iRdDt;
  assign oRdDtB  = iRdDt;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter with a behavioural SpSram and a transaction-level reference model.
module tb_sram_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          iClk = 1'b0;
  logic          iRsn = 1'b0;
  logic          iReqA = 1'b0, iWrnA = 1'b1, iReqB = 1'b0, iWrnB = 1'b1;
  logic [AW-1:0] iAddrA = '0, iAddrB = '0;
  logic [DW-1:0] iWrDtA = '0, iWrDtB = '0;
  logic          oGntA, oGntB, oRdVldA, oRdVldB, oCsn, oWrn;
  logic [DW-1:0] oRdDtA, oRdDtB, oWrDt, iRdDt;
  logic [AW-1:0] oAddr;

  always #5 iClk = ~iClk;

  sram_port_arbiter #(.SRAM_DEPTH(10), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .iClk(iClk), .iRsn(iRsn),
    .iReqA(iReqA), .iWrnA(iWrnA), .iAddrA(iAddrA), .iWrDtA(iWrDtA),
    .iReqB(iReqB), .iWrnB(iWrnB), .iAddrB(iAddrB), .iWrDtB(iWrDtB),
    .oGntA(oGntA), .oGntB(oGntB), .oRdVldA(oRdVldA), .oRdVldB(oRdVldB),
    .oRdDtA(oRdDtA), .oRdDtB(oRdDtB), .oCsn(oCsn), .oWrn(oWrn),
    .oAddr(oAddr), .oWrDt(oWrDt), .iRdDt(iRdDt)
  );

  // Behavioural SpSram: registered read data, write on the command edge
  logic [DW-1:0] sramMem [16];
  always @(posedge iClk or negedge iRsn) begin
    if (!iRsn) iRdDt <= '0;
    else if (!oCsn) begin
      if (!oWrn) sramMem[oAddr] <= oWrDt;
      else iRdDt <= sramMem[oAddr];
    end
  end

  // Reference model: memory updated in grant order, reads return 2 cycles after grant
  typedef struct { int due; bit isB; logic [DW-1:0] data; } ret_t;
  ret_t          retQ[$];
  logic [DW-1:0] refMem [16];
  bit            refLastB;
  logic          expCsn, expWrn;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expWrDt;
  int            cyc, nCmp, nErr, gntCntA, gntCntB;

  task automatic chk1(input string tag, input logic obs, input logic expv);
    nCmp++;
    assert (obs === expv) else begin
      nErr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chkW(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    nCmp++;
    assert (obs === expv) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutputs();
    bit eVA, eVB;
    logic [DW-1:0] eD;
    ret_t r;
    eVA = 1'b0; eVB = 1'b0; eD = '0;
    chk1("csn", oCsn, expCsn);
    chk1("wrn", oWrn, expWrn);
    chkW("addr", DW'(oAddr), DW'(expAddr));
    chkW("wrdt", oWrDt, expWrDt);
    if (retQ.size() > 0 && retQ[0].due == cyc) begin
      r = retQ.pop_front();
      eVA = !r.isB; eVB = r.isB; eD = r.data;
    end
    chk1("rdVldA", oRdVldA, eVA);
    chk1("rdVldB", oRdVldB, eVB);
    if (eVA) chkW("rdDtA", oRdDtA, eD);
    if (eVB) chkW("rdDtB", oRdDtB, eD);
  endtask

  task automatic doCycle(input bit rA, input bit wA, input logic [AW-1:0] aA, input logic [DW-1:0] dA,
                         input bit rB, input bit wB, input logic [AW-1:0] aB, input logic [DW-1:0] dB);
    bit eA, eB;
    iReqA = rA; iWrnA = wA; iAddrA = aA; iWrDtA = dA;
    iReqB = rB; iWrnB = wB; iAddrB = aB; iWrDtB = dB;
    #1;
`ifdef SP_ARB_RR_EN
    eA = rA && (!rB || refLastB);
`else
    eA = rA;
`endif
    eB = rB && !eA;
    chk1("gntA", oGntA, eA);
    chk1("gntB", oGntB, eB);
    if (oGntA) gntCntA++;
    if (oGntB) gntCntB++;
    if (eA || eB) begin
      refLastB = eB;
      expCsn  = 1'b0;
      expWrn  = eA ? wA : wB;
      expAddr = eA ? aA : aB;
      expWrDt = eA ? dA : dB;
      if (expWrn) retQ.push_back('{due: cyc + 2, isB: eB, data: refMem[expAddr]});
      else refMem[expAddr] = expWrDt;
    end else begin
      expCsn = 1'b1;
      expWrn = 1'b1;
    end
    @(posedge iClk);
    cyc++;
    #1;
    checkOutputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) doCycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b1, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      sramMem[i] = '0;
      refMem[i]  = '0;
    end
    nCmp = 0; nErr = 0; cyc = 0; gntCntA = 0; gntCntB = 0;
    refLastB = 1'b1;
    expCsn = 1'b1; expWrn = 1'b1; expAddr = '0; expWrDt = '0;

    // Reset state, with a request present to confirm grants are forced low
    iReqA = 1'b1;
    @(posedge iClk); @(posedge iClk); #1;
    chk1("rst_csn", oCsn, 1'b1);
    chk1("rst_wrn", oWrn, 1'b1);
    chkW("rst_addr", DW'(oAddr), 16'h0);
    chkW("rst_wrdt", oWrDt, 16'h0);
    chk1("rst_gntA", oGntA, 1'b0);
    chk1("rst_rdVldA", oRdVldA, 1'b0);
    iReqA = 1'b0;
    iRsn = 1'b1;

    // Single requester: write then read the same address
    doCycle(1'b1, 1'b0, 4'd3, 16'h1234, 1'b0, 1'b1, '0, '0);
    doCycle(1'b1, 1'b1, 4'd3, 16'h0,    1'b0, 1'b1, '0, '0);
    idle(1);
    chk1("raw_vldA", oRdVldA, 1'b1);
    chkW("raw_dtA", oRdDtA, 16'h1234);
    idle(2);

    // Return routing: B reads 5 then A reads 6
    doCycle(1'b1, 1'b0, 4'd5, 16'hBEEF, 1'b0, 1'b1, '0, '0);
    doCycle(1'b1, 1'b0, 4'd6, 16'h0F0F, 1'b0, 1'b1, '0, '0);
    idle(2);
    doCycle(1'b0, 1'b1, '0, '0, 1'b1, 1'b1, 4'd5, '0);
    doCycle(1'b1, 1'b1, 4'd6, '0, 1'b0, 1'b1, '0, '0);
    chk1("route_vldB", oRdVldB, 1'b1);
    chk1("route_noVldA", oRdVldA, 1'b0);
    chkW("route_dtB", oRdDtB, 16'hBEEF);
    idle(1);
    chk1("route_vldA", oRdVldA, 1'b1);
    chk1("route_noVldB", oRdVldB, 1'b0);
    chkW("route_dtA", oRdDtA, 16'h0F0F);
    idle(2);

    // Asynchronous reset with a read in flight
    doCycle(1'b1, 1'b1, 4'd3, '0, 1'b0, 1'b1, '0, '0);
    iReqA = 1'b1; iReqB = 1'b1;
    #2;
    iRsn = 1'b0;
    #1;
    chk1("arst_csn", oCsn, 1'b1);
    chk1("arst_wrn", oWrn, 1'b1);
    chkW("arst_addr", DW'(oAddr), 16'h0);
    chkW("arst_wrdt", oWrDt, 16'h0);
    chk1("arst_gntA", oGntA, 1'b0);
    chk1("arst_gntB", oGntB, 1'b0);
    chk1("arst_vldA", oRdVldA, 1'b0);
    chk1("arst_vldB", oRdVldB, 1'b0);
    chkW("arst_rdDtA", oRdDtA, 16'h0);
    retQ.delete();
    refLastB = 1'b1;
    expCsn = 1'b1; expWrn = 1'b1; expAddr = '0; expWrDt = '0;
    @(posedge iClk); @(posedge iClk);
    cyc += 2;
    #1;
    iRsn = 1'b1;
    idle(3);

    // Conflict: both read for 4 cycles
    gntCntA = 0; gntCntB = 0;
    for (int i = 0; i < 4; i++) doCycle(1'b1, 1'b1, 4'd1, '0, 1'b1, 1'b1, 4'd2, '0);
    idle(3);
`ifdef SP_ARB_RR_EN
    chkW("conflict_cntA", DW'(gntCntA), 16'd2);
    chkW("conflict_cntB", DW'(gntCntB), 16'd2);
`else
    chkW("conflict_cntA", DW'(gntCntA), 16'd4);
    chkW("conflict_cntB", DW'(gntCntB), 16'd0);
`endif

    // Back-to-back fill and readback by B
    for (int i = 0; i < 10; i++) doCycle(1'b0, 1'b1, '0, '0, 1'b1, 1'b0, AW'(i), DW'(100 + i));
    for (int i = 0; i < 10; i++) doCycle(1'b0, 1'b1, '0, '0, 1'b1, 1'b1, AW'(i), '0);
    idle(3);

    // Idle: command holds address/data, no pulses
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      doCycle(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), AW'($urandom_range(9, 0)), DW'($urandom),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), AW'($urandom_range(9, 0)), DW'($urandom));
    idle(3);
    chkW("drain_queue", DW'(retQ.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
